// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared tile-map defaults, direction/state types and tile indexing
package game_pkg;

    localparam int HMAXTILE_DEFAULT = 9;
    localparam int VMAXTILE_DEFAULT = 5;

    typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} dir_t;

    typedef enum logic {IDLE, HOLD} state_t;

    function automatic int tile_idx(input int hmax, input logic [3:0] h, input logic [3:0] v);
        return (hmax + 1) * int'(v) + int'(h);
    endfunction

endpackage

// File: rtl/cooldown_ctr.sv
// rtl/cooldown_ctr.sv - loadable saturating down-counter; zero is high once LEN-1 cycles have elapsed
module cooldown_ctr #(
    parameter int LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int W = $clog2(LEN + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(LEN - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/player_mover.sv
// rtl/player_mover.sv - per-player tile stepper and bomb request; PLAYER_AUTOREPEAT_EN selects level-held autorepeat
module player_mover
    import game_pkg::*;
#(
    parameter int HMAXTILE      = HMAXTILE_DEFAULT,
    parameter int VMAXTILE      = VMAXTILE_DEFAULT,
    parameter int START_H       = 0,
    parameter int START_V       = 0,
    parameter int MOVE_CYCLES   = 12_500_000,
    parameter int BOMB_COOLDOWN = 50_000_000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   key_up,
    input  logic                                   key_down,
    input  logic                                   key_left,
    input  logic                                   key_right,
    input  logic                                   key_bomb,
    input  logic [(HMAXTILE+1)*(VMAXTILE+1):0]     walk_able,
    input  logic [3:0]                             other_h,
    input  logic [3:0]                             other_v,
    output logic [3:0]                             cur_h,
    output logic [3:0]                             cur_v,
    output logic                                   atk,
    output logic                                   busy
);

    localparam int NTILES = (HMAXTILE + 1) * (VMAXTILE + 1);
    localparam int IDX_W  = $clog2(NTILES + 1);

    state_t     state_q, state_d;
    logic [3:0] cur_h_q, cur_h_d, cur_v_q, cur_v_d;
    logic       atk_q, atk_d;
    logic       bomb_prev_q, bomb_prev_d;

    logic [3:0]       keys, req;
    dir_t             dir;
    logic [3:0]       tgt_h, tgt_v;
    logic             in_range, legal, fire, step;
    logic [IDX_W-1:0] walk_idx;
    logic             move_zero, bomb_zero;

    assign keys = {key_up, key_down, key_left, key_right};

`ifdef PLAYER_AUTOREPEAT_EN
    assign req = keys;
`else
    // A blocked or bomb-suppressed edge stays armed until it is taken or the key is released.
    logic [3:0] key_prev_q, key_prev_d;
    assign req = keys & ~key_prev_q;
    assign key_prev_d = (state_q == HOLD || step) ? keys : (key_prev_q & keys);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev_q <= '0;
        end else begin
            key_prev_q <= key_prev_d;
        end
    end
`endif

    always_comb begin
        dir      = NONE;
        tgt_h    = cur_h_q;
        tgt_v    = cur_v_q;
        in_range = 1'b0;
        if (req[3])      dir = UP;
        else if (req[2]) dir = DOWN;
        else if (req[1]) dir = LEFT;
        else if (req[0]) dir = RIGHT;
        case (dir)
            UP:    begin in_range = (cur_v_q != 4'd0);              tgt_v = cur_v_q - 4'd1; end
            DOWN:  begin in_range = (cur_v_q != 4'(VMAXTILE));      tgt_v = cur_v_q + 4'd1; end
            LEFT:  begin in_range = (cur_h_q != 4'd0);              tgt_h = cur_h_q - 4'd1; end
            RIGHT: begin in_range = (cur_h_q != 4'(HMAXTILE));      tgt_h = cur_h_q + 4'd1; end
            default: in_range = 1'b0;
        endcase
    end

    always_comb begin
        walk_idx = in_range ? IDX_W'(tile_idx(HMAXTILE, tgt_h, tgt_v)) : '0;
        legal    = in_range && walk_able[walk_idx] && !((tgt_h == other_h) && (tgt_v == other_v));
        fire     = key_bomb && !bomb_prev_q && bomb_zero;
        // Bomb takes the cycle so atk always reports the tile currently occupied.
        step     = (state_q == IDLE) && legal && !fire;

        cur_h_d     = step ? tgt_h : cur_h_q;
        cur_v_d     = step ? tgt_v : cur_v_q;
        atk_d       = fire;
        bomb_prev_d = key_bomb;

        state_d = state_q;
        case (state_q)
            IDLE:    if (step) state_d = HOLD;
            HOLD:    if (move_zero || keys == 4'b0000) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_h_q     <= 4'(START_H);
            cur_v_q     <= 4'(START_V);
            atk_q       <= 1'b0;
            bomb_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_h_q     <= cur_h_d;
            cur_v_q     <= cur_v_d;
            atk_q       <= atk_d;
            bomb_prev_q <= bomb_prev_d;
        end
    end

    cooldown_ctr #(.LEN(MOVE_CYCLES)) u_move_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (step),
        .zero (move_zero)
    );

    cooldown_ctr #(.LEN(BOMB_COOLDOWN)) u_bomb_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (fire),
        .zero (bomb_zero)
    );

    assign cur_h = cur_h_q;
    assign cur_v = cur_v_q;
    assign atk   = atk_q;
    assign busy  = (state_q == HOLD);

endmodule

// File: tb/tb_player_mover.sv
// tb/tb_player_mover.sv - directed self-checking bench for player_mover
module tb_player_mover;

    localparam int HM = 9;
    localparam int VM = 5;
    localparam int WA = (HM + 1) * (VM + 1) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_up, key_down, key_left, key_right, key_bomb;
    logic [WA-1:0] walk_able;
    logic [3:0]    other_h, other_v;
    logic [3:0]    cur_h, cur_v;
    logic          atk, busy;

    int checks = 0;
    int errors = 0;

    player_mover #(
        .HMAXTILE      (HM),
        .VMAXTILE      (VM),
        .START_H       (0),
        .START_V       (0),
        .MOVE_CYCLES   (4),
        .BOMB_COOLDOWN (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_bomb  (key_bomb),
        .walk_able (walk_able),
        .other_h   (other_h),
        .other_v   (other_v),
        .cur_h     (cur_h),
        .cur_v     (cur_v),
        .atk       (atk),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_keys();
        key_up = 0; key_down = 0; key_left = 0; key_right = 0; key_bomb = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_keys();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic move_once(input int d);
        key_up = (d == 0); key_down = (d == 1); key_left = (d == 2); key_right = (d == 3);
        tick();
        clear_keys();
        tick();
    endtask

    initial begin
        walk_able = '1;
        other_h = 4'd9;
        other_v = 4'd5;
        do_reset();

        chk("reset_h", cur_h, 0);
        chk("reset_v", cur_v, 0);
        chk("reset_atk", atk, 0);
        chk("reset_busy", busy, 0);

        // held right from reset
        key_right = 1;
        tick();
        chk("hold_c1_h", cur_h, 1);
        chk("hold_c1_busy", busy, 1);
        repeat (4) tick();
        chk("hold_c5_busy", busy, 0);
        tick();
`ifdef PLAYER_AUTOREPEAT_EN
        chk("hold_c6_h", cur_h, 2);
`else
        chk("hold_c6_h", cur_h, 1);
`endif
        repeat (5) tick();
`ifdef PLAYER_AUTOREPEAT_EN
        chk("hold_c11_h", cur_h, 3);
`else
        chk("hold_c11_h", cur_h, 1);
`endif

        // underflow at the origin, up wins over left
        do_reset();
        key_left = 1; key_up = 1;
        tick();
        chk("uflow_h", cur_h, 0);
        chk("uflow_v", cur_v, 0);
        chk("uflow_busy", busy, 0);
        key_up = 0;
        tick();
        chk("uflow_left_h", cur_h, 0);
        chk("uflow_left_busy", busy, 0);

        // walk_able blocking then release
        do_reset();
        walk_able[1] = 1'b0;
        key_right = 1;
        tick();
        chk("wall_h", cur_h, 0);
        chk("wall_busy", busy, 0);
        walk_able[1] = 1'b1;
        tick();
        chk("wall_open_h", cur_h, 1);
        chk("wall_open_v", cur_v, 0);

        // opponent blocking and priority without fallback
        do_reset();
        other_h = 4'd0; other_v = 4'd1;
        key_down = 1;
        tick();
        chk("opp_v", cur_v, 0);
        chk("opp_busy", busy, 0);
        other_h = 4'd9; other_v = 4'd5;
        tick();
        chk("opp_gone_v", cur_v, 1);
        do_reset();
        other_h = 4'd0; other_v = 4'd1;
        key_up = 1; key_right = 1;
        tick();
        chk("prio_h", cur_h, 0);
        chk("prio_v", cur_v, 0);
        key_up = 0;
        tick();
        chk("prio_right_h", cur_h, 1);
        other_h = 4'd9; other_v = 4'd5;

        // bomb edges at cycles 0, 3, 10
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            chk($sformatf("bomb_atk_c%0d", c), atk, (c == 1 || c == 11) ? 1 : 0);
            key_bomb = (c == 0 || c == 3 || c == 10);
            tick();
        end
        key_bomb = 0;

        // bomb coinciding with a step
        do_reset();
        key_bomb = 1; key_right = 1;
        tick();
        chk("bs_atk1", atk, 1);
        chk("bs_h1", cur_h, 0);
        tick();
        chk("bs_atk2", atk, 0);
        chk("bs_h2", cur_h, 1);

        // reset during HOLD with bomb cooldown running
        do_reset();
        move_once(3); move_once(3); move_once(3); move_once(1);
        chk("walk_h", cur_h, 3);
        chk("walk_v", cur_v, 1);
        key_bomb = 1;
        tick();
        chk("pre_atk", atk, 1);
        key_bomb = 0; key_down = 1;
        tick();
        tick();
        chk("pre_h", cur_h, 3);
        chk("pre_v", cur_v, 2);
        chk("pre_busy", busy, 1);
        rst = 1;
        tick();
        chk("mid_rst_h", cur_h, 0);
        chk("mid_rst_v", cur_v, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 0;
        clear_keys();
        key_bomb = 1;
        tick();
        chk("post_rst_atk", atk, 1);
        key_bomb = 0;
        tick();
        chk("post_rst_atk_off", atk, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
